// File: rtl/game_state_controller_pkg.sv
// Game-state encodings shared by the controller, countdown and renderer,
// plus the countdown zero-detect helper.
package game_state_controller_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        OPENING_SCREEN = 2'b01,
        GAME_RUNNING   = 2'b10,
        GAME_OVER      = 2'b11
    } game_state_t;

    function automatic logic digits_zero(input logic [3:0] d0, input logic [3:0] d1,
                                         input logic [3:0] d2, input logic [3:0] d3);
        return (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
    endfunction

endpackage

// File: rtl/game_state_controller_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous pushbutton followed by a
// registered rising-edge detector producing a one-cycle pulse.
module game_state_controller_btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [2:0] fill_r;

    // fill_r masks the edge detector until the chain holds real pin samples,
    // so a button already held at reset release is not mistaken for a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            fill_r  <= 3'b000;
            pulse   <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fill_r  <= {fill_r[1:0], 1'b1};
            pulse   <= sync2_r & ~prev_r & fill_r[2];
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// Master game FSM: opening screen, running game, win/lose decision with
// latched remaining time, and a minimum hold on the game-over screen.
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int OPEN_CYCLES      = 100_000_000,
    parameter int OVER_HOLD_CYCLES = 50_000_000,
    parameter int CNT_W            = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       collision,
    input  logic [3:0] num0_w,
    input  logic [3:0] num1_w,
    input  logic [3:0] num2_w,
    input  logic [3:0] num3_w,
    output logic [1:0] game_state_w,
    output logic       game_won,
    output logic       game_lost,
    output logic [7:0] time_left
);

    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] OVER_HOLD = CNT_W'(OVER_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    game_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             armed_r;
    logic             start_pulse_s;
    logic             tz_s;

    assign tz_s         = digits_zero(num0_w, num1_w, num2_w, num3_w);
    assign game_state_w = state_r;

    game_state_controller_btn_sync_edge u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_btn),
        .pulse (start_pulse_s)
    );

    // Game FSM; armed_r blocks a win on zeros left over from the previous game.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            armed_r   <= 1'b0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
            time_left <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    game_won  <= 1'b0;
                    game_lost <= 1'b0;
                    time_left <= 8'h00;
                    if (start_pulse_s) begin
                        state_r <= OPENING_SCREEN;
                        cnt_r   <= '0;
                    end
                end
                OPENING_SCREEN: begin
                    if (cnt_r == OPEN_LAST) begin
                        state_r <= GAME_RUNNING;
                        armed_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                GAME_RUNNING: begin
                    if (collision) begin
                        state_r   <= GAME_OVER;
                        cnt_r     <= '0;
                        game_lost <= 1'b1;
                        time_left <= {num1_w, num0_w};
                    end else if (armed_r && tz_s) begin
                        state_r   <= GAME_OVER;
                        cnt_r     <= '0;
                        game_won  <= 1'b1;
                        time_left <= 8'h00;
                    end else if (!tz_s) begin
                        armed_r <= 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (start_pulse_s && (cnt_r == OVER_HOLD)) begin
                        state_r   <= IDLE;
                        game_won  <= 1'b0;
                        game_lost <= 1'b0;
                        time_left <= 8'h00;
                    end else if (cnt_r != OVER_HOLD) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized and directed bench for game_state_controller, checked every cycle
// against a behavioural model of the game rules.
module tb_game_state_controller;

    localparam int OPEN_C = 8;
    localparam int HOLD_C = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       collision;
    logic [3:0] num0_w, num1_w, num2_w, num3_w;
    logic [1:0] game_state_w;
    logic       game_won, game_lost;
    logic [7:0] time_left;

    int checks = 0;
    int errors = 0;

    // model state
    logic [1:0] m_state;
    logic       m_won, m_lost, m_seen, m_init;
    logic [7:0] m_tl;
    int         m_since;
    logic       h_v [5];
    logic       h_b [5];

    game_state_controller #(
        .OPEN_CYCLES      (OPEN_C),
        .OVER_HOLD_CYCLES (HOLD_C),
        .CNT_W            (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .collision    (collision),
        .num0_w       (num0_w),
        .num1_w       (num1_w),
        .num2_w       (num2_w),
        .num3_w       (num3_w),
        .game_state_w (game_state_w),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .time_left    (time_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input logic [15:0] d);
        {num3_w, num2_w, num1_w, num0_w} = d;
    endtask

    // A start press reaches the FSM three edges after the pin sample that first
    // reads high, provided the sample before it read low and both were taken
    // out of reset.
    initial begin
        logic start_evt, tz;
        m_init = 1'b0;
        m_state = 2'b00; m_won = 1'b0; m_lost = 1'b0; m_tl = 8'h00;
        m_seen = 1'b0; m_since = 0;
        for (int i = 0; i < 5; i++) begin h_v[i] = 1'b0; h_b[i] = 1'b0; end
        forever begin
            @(posedge clk);
            for (int i = 4; i > 0; i--) begin h_v[i] = h_v[i-1]; h_b[i] = h_b[i-1]; end
            h_v[0] = rst;
            h_b[0] = start_btn;
            start_evt = h_v[3] && h_b[3] && h_v[4] && !h_b[4];
            tz = ({num3_w, num2_w, num1_w, num0_w} == 16'h0000);
            if (!rst) begin
                m_init = 1'b1;
                m_state = 2'b00; m_won = 1'b0; m_lost = 1'b0; m_tl = 8'h00;
                for (int i = 0; i < 5; i++) h_v[i] = 1'b0;
            end else if (m_state == 2'b00) begin
                m_won = 1'b0; m_lost = 1'b0; m_tl = 8'h00;
                if (start_evt) begin m_state = 2'b01; m_since = 0; end
            end else if (m_state == 2'b01) begin
                m_since++;
                if (m_since == OPEN_C) begin m_state = 2'b10; m_seen = 1'b0; end
            end else if (m_state == 2'b10) begin
                if (collision) begin
                    m_state = 2'b11; m_lost = 1'b1; m_tl = {num1_w, num0_w}; m_since = 0;
                end else if (m_seen && tz) begin
                    m_state = 2'b11; m_won = 1'b1; m_tl = 8'h00; m_since = 0;
                end else if (!tz) begin
                    m_seen = 1'b1;
                end
            end else begin
                m_since++;
                if (start_evt && m_since > HOLD_C) begin
                    m_state = 2'b00; m_won = 1'b0; m_lost = 1'b0; m_tl = 8'h00;
                end
            end
            #1;
            if (m_init) begin
                chk("state", 32'(game_state_w), 32'(m_state));
                chk("game_won", 32'(game_won), 32'(m_won));
                chk("game_lost", 32'(game_lost), 32'(m_lost));
                chk("time_left", 32'(time_left), 32'(m_tl));
            end
        end
    end

    task automatic start_game();
        int tries = 0;
        collision = 1'b0;
        while (game_state_w != 2'b10 && tries < 40) begin
            if (game_state_w == 2'b01) begin
                step(1);
            end else begin
                start_btn = 1'b1; step(3);
                start_btn = 1'b0; step(3);
            end
            tries++;
        end
        chk("start_game_reached_running", 32'(game_state_w), 32'd2);
    endtask

    initial begin
        rst = 1'b0; start_btn = 1'b1; collision = 1'b0;
        set_digits(16'h0000);
        step(3);
        chk("reset_state", 32'(game_state_w), 32'd0);
        chk("reset_won", 32'(game_won), 32'd0);
        chk("reset_lost", 32'(game_lost), 32'd0);
        chk("reset_time_left", 32'(time_left), 32'd0);
        rst = 1'b1;
        step(8);
        chk("held_button_after_reset", 32'(game_state_w), 32'd0);

        // start flow and opening-screen length
        start_btn = 1'b0; step(3);
        start_btn = 1'b1;
        step(3); chk("not_yet_opening", 32'(game_state_w), 32'd0);
        step(1); chk("opening", 32'(game_state_w), 32'd1);
        start_btn = 1'b0;
        step(7); chk("still_opening", 32'(game_state_w), 32'd1);
        step(1); chk("running", 32'(game_state_w), 32'd2);
        step(5); chk("stale_zero_no_win", 32'(game_state_w), 32'd2);

        // win after countdown 25 -> 01 -> 00
        set_digits(16'h0025); step(1);
        set_digits(16'h0001); step(1);
        set_digits(16'h0000); step(1);
        chk("win_state", 32'(game_state_w), 32'd3);
        chk("win_won", 32'(game_won), 32'd1);
        chk("win_lost", 32'(game_lost), 32'd0);
        chk("win_time_left", 32'(time_left), 32'd0);

        // game-over hold: early press dropped, late press accepted
        start_btn = 1'b1; step(6);
        chk("early_press_dropped", 32'(game_state_w), 32'd3);
        start_btn = 1'b0; step(2);
        start_btn = 1'b1; step(3);
        chk("late_press_pending", 32'(game_state_w), 32'd3);
        step(1);
        chk("back_to_idle", 32'(game_state_w), 32'd0);
        chk("idle_won_cleared", 32'(game_won), 32'd0);
        start_btn = 1'b0; step(2);

        // collision latches {tens, units}
        start_game();
        set_digits(16'h0017); step(1);
        collision = 1'b1; step(1); collision = 1'b0;
        chk("coll_state", 32'(game_state_w), 32'd3);
        chk("coll_lost", 32'(game_lost), 32'd1);
        chk("coll_won", 32'(game_won), 32'd0);
        chk("coll_time_left", 32'(time_left), 32'h17);

        // collision beats simultaneous timer zero
        start_game();
        set_digits(16'h0033); step(1);
        set_digits(16'h0000); collision = 1'b1; step(1); collision = 1'b0;
        chk("tie_lost", 32'(game_lost), 32'd1);
        chk("tie_won", 32'(game_won), 32'd0);
        chk("tie_time_left", 32'(time_left), 32'd0);

        // reset while running and while in game over
        start_game();
        set_digits(16'h0042); step(2);
        rst = 1'b0; step(1);
        chk("rst_running_state", 32'(game_state_w), 32'd0);
        rst = 1'b1; step(1);
        start_game();
        collision = 1'b1; step(1); collision = 1'b0;
        chk("over_before_rst", 32'(game_state_w), 32'd3);
        rst = 1'b0; step(1);
        chk("rst_over_state", 32'(game_state_w), 32'd0);
        chk("rst_over_lost", 32'(game_lost), 32'd0);
        chk("rst_over_time_left", 32'(time_left), 32'd0);
        rst = 1'b1; step(1);

        // randomized play
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            collision = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) begin
                set_digits(16'h0000);
            end else begin
                num0_w = 4'($urandom_range(0, 9));
                num1_w = 4'($urandom_range(0, 9));
                num2_w = 4'($urandom_range(0, 9));
                num3_w = 4'($urandom_range(0, 9));
            end
            step(1);
        end

        rst = 1'b1; collision = 1'b0; step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Master game FSM for the asteroid-escape design; drives the 2-bit game state consumed by the countdown timer, renderer and input logic.
- Consumes the countdown's four BCD digits (zero-detect), a start button and the collision flag from the object logic; decides win/lose and latches remaining time.
- Runs on the system clock; all timing in system-clock cycles.

Parameters:
OPEN_CYCLES, 100_000_000, cycles spent in OPENING_SCREEN before auto-advance to GAME_RUNNING (min 1).
OVER_HOLD_CYCLES, 50_000_000, minimum cycles in GAME_OVER before a start press is accepted (min 1).
CNT_W, 27, width of the shared hold counter; must hold max(OPEN_CYCLES, OVER_HOLD_CYCLES).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start_btn  in  1  raw start pushbutton, asynchronous to clk
collision  in  1  ship/asteroid collision, level, synchronous to clk
num0_w  in  4  countdown units digit (BCD)
num1_w  in  4  countdown tens digit (BCD)
num2_w  in  4  countdown digit 2 (BCD)
num3_w  in  4  countdown digit 3 (BCD)
game_state_w  out  2  00 IDLE, 01 OPENING_SCREEN, 10 GAME_RUNNING, 11 GAME_OVER
game_won  out  1  1 = survived until timer hit zero; valid in GAME_OVER
game_lost  out  1  1 = collision ended game; valid in GAME_OVER
time_left  out  8  {num1_w,num0_w} latched at collision; 0 on win

Behaviour:
- Reset (rst==0 at posedge clk): state IDLE, game_won=0, game_lost=0, time_left=0, hold counter=0, armed=0, sync/edge flops=0.
- start_btn: 2-flop synchronizer, then rising-edge detect -> 1-cycle start_pulse; 3-cycle latency from pin to pulse. Held button yields one pulse only.
- Zero detect: tz = (num0..num3 all 4'd0), combinational on inputs.
- armed flag: cleared on entry to GAME_RUNNING; set in GAME_RUNNING on first cycle with tz==0. Win is only recognised when armed==1 (countdown reloads on its slow clock, so stale zeros from the prior game must be ignored).
- IDLE: outputs game_won/game_lost/time_left cleared. start_pulse -> OPENING_SCREEN, counter=0.
- OPENING_SCREEN: counter increments each cycle; when counter==OPEN_CYCLES-1 -> GAME_RUNNING next cycle. start_pulse and collision ignored.
- GAME_RUNNING, priority per cycle: (1) collision==1 -> GAME_OVER, game_lost=1, time_left={num1_w,num0_w}; (2) armed && tz -> GAME_OVER, game_won=1, time_left=0; (3) stay. Collision wins over simultaneous timer-zero. start_pulse ignored.
- GAME_OVER: counter=0 on entry, increments saturating at OVER_HOLD_CYCLES. start_pulse with counter==OVER_HOLD_CYCLES -> IDLE; earlier presses dropped (not queued). game_won/game_lost/time_left held stable.
- All state transitions take effect on the clock edge following the qualifying condition; outputs are registered.
- Reset mid-operation in any state returns to IDLE on that edge; no partial results retained.
- game_won and game_lost never both 1.

Decomposition:
- Shared package/header: state encodings IDLE/OPENING_SCREEN/GAME_RUNNING/GAME_OVER (2'b00..2'b11), shared with the countdown and renderer so no block redefines them locally.
- One natural sub-module: btn_sync_edge (2-flop synchronizer + rising-edge pulse), reusable for other pushbuttons.

Test Plan:
- Reset: hold rst=0 3 cycles with start_btn=1 -> state 00, won=lost=0, time_left=0; release with button held -> no transition.
- Start flow (OPEN_CYCLES=8): pulse start_btn in IDLE -> state 01 after 3-4 cycles, state 10 exactly 8 cycles later.
- Win: digits 25,...,01,00 while running -> state 11, game_won=1, time_left=0; digits forced 00 on first running cycle (stale) -> no win until a nonzero value is seen first.
- Collision: collision=1 while digits read 1,7 -> state 11, game_lost=1, time_left=8'h17; collision and tz in same cycle -> lost=1, won=0.
- Game-over hold (OVER_HOLD_CYCLES=10): press start 4 cycles after entry -> stays 11; press again after 10 cycles -> 00 with flags cleared.
- Reset in GAME_RUNNING and in GAME_OVER -> 00 on the next edge, flags 0.
